// File: rtl/alarm_setter_pkg.sv
// Shared encodings and digit limits for the alarm-time editor.
// The state codes double as the field code shown on the field output.
package alarm_setter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ED_HORA = 2'b01,
        ED_DMIN = 2'b10,
        ED_UMIN = 2'b11
    } state_e;

    localparam logic [1:0] FIELD_NONE = 2'b00;
    localparam logic [1:0] FIELD_HORA = 2'b01;
    localparam logic [1:0] FIELD_DMIN = 2'b10;
    localparam logic [1:0] FIELD_UMIN = 2'b11;

    localparam logic [3:0] HORA_MIN = 4'd1;
    localparam logic [3:0] HORA_MAX = 4'd12;
    localparam logic [3:0] HORA_RST = 4'd12;
    localparam logic [3:0] UMIN_MAX = 4'd9;
    localparam logic [3:0] DMIN_MAX = 4'd5;

    // One up/down step of a digit that wraps inside [lo, hi].
    function automatic logic [3:0] digit_step(input logic [3:0] v,
                                              input logic [3:0] lo,
                                              input logic [3:0] hi,
                                              input logic       up);
        if (up) begin
            return (v >= hi) ? lo : v + 4'd1;
        end
        return (v <= lo) ? hi : v - 4'd1;
    endfunction

endpackage

// File: rtl/alarm_setter_btn_repeat.sv
// Rising-edge detector with press-and-hold auto-repeat for one up/down button.
// step_o pulses on the press, after REP_DELAY held cycles, then every REP_RATE cycles.
module alarm_setter_btn_repeat #(
    parameter int REP_DELAY = 25000000,
    parameter int REP_RATE  = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    input  logic block_i,
    input  logic active_i,
    input  logic clear_i,
    output logic press_o,
    output logic step_o
);
    localparam int CMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DLY_END  = CW'(REP_DELAY - 1);
    localparam logic [CW-1:0] RATE_END = CW'(REP_RATE - 1);

    logic          btn_q;
    logic          press_q;
    logic          step_q, step_d;
    logic          rep_q, rep_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise;
    logic          hold;

    assign rise = btn_i & ~btn_q;
    // The other direction held at the same time freezes repeat entirely.
    assign hold = btn_i & ~block_i & active_i;

    always_comb begin
        cnt_d  = cnt_q;
        rep_d  = rep_q;
        step_d = 1'b0;
        if (!hold || clear_i) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (rise) begin
            step_d = 1'b1;
            cnt_d  = '0;
            rep_d  = 1'b0;
        end else if (!rep_q && cnt_q == DLY_END) begin
            step_d = 1'b1;
            cnt_d  = '0;
            rep_d  = 1'b1;
        end else if (rep_q && cnt_q == RATE_END) begin
            step_d = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q   <= 1'b0;
            press_q <= 1'b0;
            step_q  <= 1'b0;
            rep_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            btn_q   <= btn_i;
            press_q <= rise;
            step_q  <= step_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;
    assign step_o  = step_q;

endmodule

// File: rtl/alarm_setter.sv
// Button-driven alarm-time editor: edits a working copy of hora/dmin/umin and
// commits all three digits at once when the last field is confirmed.
module alarm_setter
    import alarm_setter_pkg::*;
#(
    parameter int REP_DELAY = 25000000,
    parameter int REP_RATE  = 5000000,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_on,
    output logic [3:0] umin,
    output logic [3:0] dmin,
    output logic [3:0] hora,
    output logic       ajustalarma,
    output logic       editing,
    output logic [1:0] field,
    output logic [3:0] disp_umin,
    output logic [3:0] disp_dmin,
    output logic [3:0] disp_hora,
    output logic [1:0] dbg_state
);
    localparam int SW = $clog2(TIMEOUT_S + 1);
    localparam logic [SW-1:0] SEC_LAST = SW'(TIMEOUT_S - 1);

    state_e        state_q;
    logic [3:0]    umin_q, dmin_q, hora_q;
    logic [3:0]    w_umin_q, w_dmin_q, w_hora_q;
    logic [3:0]    w_umin_d, w_dmin_d, w_hora_d;
    logic          en_q;
    logic [SW-1:0] sec_q;
    logic          mode_q, mode_ev_q;
    logic          on_q, on_ev_q;
    logic          up_press, up_step;
    logic          dn_press, dn_step;
    logic          in_edit;
    logic          any_ev;
    logic          timeout;

    assign in_edit = (state_q != IDLE);
    assign any_ev  = mode_ev_q | on_ev_q | up_press | dn_press;
    assign timeout = tick_1hz & ~any_ev & (sec_q == SEC_LAST);

    alarm_setter_btn_repeat #(.REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_rep_up (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (btn_up),
        .block_i  (btn_down),
        .active_i (in_edit),
        .clear_i  (mode_ev_q & in_edit),
        .press_o  (up_press),
        .step_o   (up_step)
    );

    alarm_setter_btn_repeat #(.REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_rep_dn (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (btn_down),
        .block_i  (btn_up),
        .active_i (in_edit),
        .clear_i  (mode_ev_q & in_edit),
        .press_o  (dn_press),
        .step_o   (dn_step)
    );

    always_comb begin
        w_hora_d = w_hora_q;
        w_dmin_d = w_dmin_q;
        w_umin_d = w_umin_q;
        if (up_step ^ dn_step) begin
            case (state_q)
                ED_HORA: w_hora_d = digit_step(w_hora_q, HORA_MIN, HORA_MAX, up_step);
                ED_DMIN: w_dmin_d = digit_step(w_dmin_q, 4'd0, DMIN_MAX, up_step);
                ED_UMIN: w_umin_d = digit_step(w_umin_q, 4'd0, UMIN_MAX, up_step);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            umin_q    <= 4'd0;
            dmin_q    <= 4'd0;
            hora_q    <= HORA_RST;
            w_umin_q  <= 4'd0;
            w_dmin_q  <= 4'd0;
            w_hora_q  <= HORA_RST;
            en_q      <= 1'b0;
            sec_q     <= '0;
            mode_q    <= 1'b0;
            mode_ev_q <= 1'b0;
            on_q      <= 1'b0;
            on_ev_q   <= 1'b0;
        end else begin
            mode_q    <= btn_mode;
            mode_ev_q <= btn_mode & ~mode_q;
            on_q      <= btn_on;
            on_ev_q   <= btn_on & ~on_q;

            if (any_ev || !in_edit) begin
                sec_q <= '0;
            end else if (tick_1hz) begin
                sec_q <= sec_q + SW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (on_ev_q) en_q <= ~en_q;
                    if (mode_ev_q) begin
                        w_umin_q <= umin_q;
                        w_dmin_q <= dmin_q;
                        w_hora_q <= hora_q;
                        state_q  <= ED_HORA;
                    end
                end
                default: begin
                    // A mode event discards any step that lands in the same cycle.
                    if (mode_ev_q) begin
                        if (state_q == ED_UMIN) begin
                            umin_q  <= w_umin_q;
                            dmin_q  <= w_dmin_q;
                            hora_q  <= w_hora_q;
                            state_q <= IDLE;
                        end else if (state_q == ED_HORA) begin
                            state_q <= ED_DMIN;
                        end else begin
                            state_q <= ED_UMIN;
                        end
                    end else if (timeout) begin
                        w_umin_q <= umin_q;
                        w_dmin_q <= dmin_q;
                        w_hora_q <= hora_q;
                        state_q  <= IDLE;
                    end else begin
                        w_umin_q <= w_umin_d;
                        w_dmin_q <= w_dmin_d;
                        w_hora_q <= w_hora_d;
                    end
                end
            endcase
        end
    end

    assign umin        = umin_q;
    assign dmin        = dmin_q;
    assign hora        = hora_q;
    assign ajustalarma = en_q;
    assign editing     = in_edit;
    assign field       = state_q;
    assign dbg_state   = state_q;
    assign disp_umin   = in_edit ? w_umin_q : umin_q;
    assign disp_dmin   = in_edit ? w_dmin_q : dmin_q;
    assign disp_hora   = in_edit ? w_hora_q : hora_q;

endmodule

// File: tb/tb_alarm_setter.sv
// Directed bench for alarm_setter: field editing, wraps, auto-repeat,
// timeout, reset mid-edit and enable toggling, with hand-computed expectations.
module tb_alarm_setter;
    localparam int REP_DELAY = 20;
    localparam int REP_RATE  = 5;
    localparam int TIMEOUT_S = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_on = 1'b0;
    logic [3:0] umin, dmin, hora;
    logic       ajustalarma, editing;
    logic [1:0] field;
    logic [3:0] disp_umin, disp_dmin, disp_hora;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [11:0] exp_q[$];

    alarm_setter #(
        .REP_DELAY (REP_DELAY),
        .REP_RATE  (REP_RATE),
        .TIMEOUT_S (TIMEOUT_S)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .btn_mode    (btn_mode),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_on      (btn_on),
        .umin        (umin),
        .dmin        (dmin),
        .hora        (hora),
        .ajustalarma (ajustalarma),
        .editing     (editing),
        .field       (field),
        .disp_umin   (disp_umin),
        .disp_dmin   (disp_dmin),
        .disp_hora   (disp_hora),
        .dbg_state   (dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drivers: 0 mode, 1 up, 2 down, 3 on
    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_mode = v;
            1: btn_up   = v;
            2: btn_down = v;
            default: btn_on = v;
        endcase
    endtask

    task automatic push(input int b, input int times);
        for (int i = 0; i < times; i++) begin
            set_btn(b, 1'b1);
            cyc(2);
            set_btn(b, 1'b0);
            cyc(3);
        end
    endtask

    task automatic tick(input int times);
        for (int i = 0; i < times; i++) begin
            tick_1hz = 1'b1;
            cyc(1);
            tick_1hz = 1'b0;
            cyc(2);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(2);
    endtask

    // Scoreboard: committed {hora, dmin, umin} after each commit
    task automatic check_commit(input string tag);
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_empty_queue"}, 16'd1, 16'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {4'd0, hora, dmin, umin}, {4'd0, e});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Reset state
        check("rst_umin", umin, 0);
        check("rst_dmin", dmin, 0);
        check("rst_hora", hora, 12);
        check("rst_en", ajustalarma, 0);
        check("rst_editing", editing, 0);
        check("rst_field", field, 0);
        check("rst_disp_hora", disp_hora, 12);

        // Full edit 12 -> 3, dmin 4, umin 7
        push(0, 1);
        check("edit_field_hora", field, 1);
        check("edit_editing", editing, 1);
        push(1, 3);
        check("edit_disp_hora", disp_hora, 3);
        check("edit_hora_uncommitted", hora, 12);
        push(0, 1);
        check("edit_field_dmin", field, 2);
        push(1, 4);
        check("edit_disp_dmin", disp_dmin, 4);
        check("edit_dmin_uncommitted", dmin, 0);
        push(0, 1);
        check("edit_field_umin", field, 3);
        push(1, 7);
        check("edit_disp_umin", disp_umin, 7);
        check("edit_umin_uncommitted", umin, 0);
        check("edit_hora_still_old", hora, 12);
        push(0, 1);
        check("commit_field", field, 0);
        exp_q.push_back({4'd3, 4'd4, 4'd7});
        check_commit("commit1");

        // Wraps: hora 3->2->1->12, dmin 4->5->0, umin 7->8->9->0->9
        push(0, 1);
        check("wrap_copy_hora", disp_hora, 3);
        push(2, 2);
        check("wrap_hora_at_min", disp_hora, 1);
        push(2, 1);
        check("wrap_hora_down", disp_hora, 12);
        push(0, 1);
        push(1, 1);
        check("wrap_dmin_at_max", disp_dmin, 5);
        push(1, 1);
        check("wrap_dmin_up", disp_dmin, 0);
        push(0, 1);
        push(1, 3);
        check("wrap_umin_up", disp_umin, 0);
        check("wrap_no_carry_dmin", disp_dmin, 0);
        push(2, 1);
        check("wrap_umin_down", disp_umin, 9);
        push(0, 1);
        exp_q.push_back({4'd12, 4'd0, 4'd9});
        check_commit("commit2");

        // Auto-repeat: 5 steps from 9 -> 4; then up+down together -> no change
        push(0, 3);
        check("rep_field_umin", field, 3);
        btn_up = 1'b1;
        cyc(REP_DELAY + 3 * REP_RATE + 2);
        btn_up = 1'b0;
        cyc(3);
        check("rep_five_steps", disp_umin, 4);
        btn_up = 1'b1;
        btn_down = 1'b1;
        cyc(REP_DELAY + 2 * REP_RATE);
        btn_up = 1'b0;
        btn_down = 1'b0;
        cyc(3);
        check("rep_both_held", disp_umin, 4);
        push(0, 1);
        exp_q.push_back({4'd12, 4'd0, 4'd4});
        check_commit("commit3");

        // Timeout abandons edit
        push(0, 1);
        push(1, 1);
        check("to_disp_hora", disp_hora, 1);
        tick(TIMEOUT_S - 1);
        check("to_still_editing", editing, 1);
        tick(1);
        check("to_editing", editing, 0);
        check("to_field", field, 0);
        check("to_disp_hora_restored", disp_hora, 12);
        exp_q.push_back({4'd12, 4'd0, 4'd4});
        check_commit("to_committed");

        // Reset mid-edit
        push(0, 1);
        push(1, 2);
        check("rm_disp_hora", disp_hora, 2);
        do_reset();
        check("rm_editing", editing, 0);
        check("rm_disp_hora", disp_hora, 12);
        exp_q.push_back({4'd12, 4'd0, 4'd0});
        check_commit("rm_committed");

        // Enable toggle, ignored while editing; mode beats up
        push(3, 1);
        check("on_idle", ajustalarma, 1);
        push(0, 1);
        push(3, 1);
        check("on_in_edit", ajustalarma, 1);
        btn_mode = 1'b1;
        btn_up = 1'b1;
        cyc(2);
        btn_mode = 1'b0;
        btn_up = 1'b0;
        cyc(3);
        check("mode_up_field", field, 2);
        check("mode_up_hora", disp_hora, 12);
        push(0, 2);
        check("commit_keeps_en", ajustalarma, 1);
        exp_q.push_back({4'd12, 4'd0, 4'd0});
        check_commit("commit4");
        push(3, 1);
        check("on_toggle_back", ajustalarma, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
